// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: on a miss, read one 16-byte block from memory and write it into the cache data and tag arrays
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        memory_enable,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  cache_word_offset,
  output logic [15:0] cache_data,
  output logic        write_tag_array
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t      r_state;
  logic [15:0] r_base;
  logic [3:0]  r_issue;
  logic [3:0]  r_recv;
  logic        w_issue;
  if (BLOCK_WORDS != 8) begin : g_bad_block
    $error("cache_fill_fsm: port widths fix BLOCK_WORDS at 8");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("cache_fill_fsm: MEM_LATENCY must be positive");
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_issue <= '0;
      r_recv  <= '0;
    end else if (r_state == IDLE) begin
      if (miss_detected) begin
        r_state <= FILL;
        r_base  <= miss_address & 16'hFFF0;
        r_issue <= '0;
        r_recv  <= '0;
      end
    end else begin
      if (w_issue) r_issue <= r_issue + 4'd1;
      if (memory_data_valid) r_recv <= r_recv + 4'd1;
      if (write_tag_array) r_state <= IDLE;
    end
  end
  always_comb begin
    fsm_busy          = r_state == FILL;
    w_issue           = fsm_busy && r_issue < 4'(BLOCK_WORDS);
    memory_enable     = w_issue;
    memory_address    = w_issue ? r_base + {11'b0, r_issue[2:0], 1'b0} : '0;
    write_data_array  = fsm_busy && memory_data_valid;
    cache_word_offset = write_data_array ? r_recv[2:0] : '0;
    cache_data        = memory_data;
    write_tag_array   = write_data_array && r_recv == 4'(BLOCK_WORDS - 1);
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed cycle-by-cycle checks of the cache fill controller
module tb_cache_fill_fsm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic [15:0] memory_data = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy;
  logic        memory_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  cache_word_offset;
  logic [15:0] cache_data;
  logic        write_tag_array;
  int          tests = 0;
  int          failed = 0;
  logic [38:0] got;
  logic [38:0] exp;
  cache_fill_fsm #(.BLOCK_WORDS(8), .MEM_LATENCY(4)) dut (
    .clk(clk),
    .rst(rst),
    .miss_detected(miss_detected),
    .miss_address(miss_address),
    .memory_data(memory_data),
    .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy),
    .memory_enable(memory_enable),
    .memory_address(memory_address),
    .write_data_array(write_data_array),
    .cache_word_offset(cache_word_offset),
    .cache_data(cache_data),
    .write_tag_array(write_tag_array)
  );
  always #5 clk = ~clk;
  always_comb got = {fsm_busy, memory_enable, memory_address, write_data_array, cache_word_offset, write_tag_array, cache_data};
  task automatic test_reset();
    rst = 1'b1;
    miss_detected = 1'b1;
    miss_address = 16'h1236;
    memory_data_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      memory_data = 16'h1234 + 16'(c);
      if (c == 3) begin
        rst = 1'b0;
        miss_detected = 1'b0;
        memory_data_valid = 1'b0;
      end
      @(negedge clk);
      exp = {1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 16'h1234 + 16'(c)};
      tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL reset c=%0d got %h exp %h", c, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_basic();
    logic        b, e, w, t;
    logic [15:0] a;
    logic [2:0]  o;
    miss_address = 16'h1236;
    for (int c = 0; c <= 14; c++) begin
      miss_detected = c == 0;
      memory_data_valid = c >= 5 && c <= 12;
      memory_data = memory_data_valid ? 16'hA000 + 16'(c - 5) : 16'h5A5A;
      @(negedge clk);
      b = c >= 1 && c <= 12;
      e = c >= 1 && c <= 8;
      a = e ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0;
      w = c >= 5 && c <= 12;
      o = w ? 3'(c - 5) : 3'd0;
      t = c == 12;
      exp = {b, e, a, w, o, t, memory_data};
      tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL basic c=%0d got %h exp %h", c, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_back_to_back();
    logic        b, e, w, t;
    logic [15:0] a;
    logic [2:0]  o;
    for (int c = 0; c <= 26; c++) begin
      miss_detected = c <= 13;
      miss_address = c < 10 ? 16'h1236 : 16'h4568;
      memory_data_valid = (c >= 5 && c <= 12) || (c >= 18 && c <= 25);
      memory_data = memory_data_valid ? 16'hB000 + 16'(c) : 16'h0F0F;
      @(negedge clk);
      b = (c >= 1 && c <= 12) || (c >= 14 && c <= 25);
      e = (c >= 1 && c <= 8) || (c >= 14 && c <= 21);
      a = !e ? 16'h0 : c <= 8 ? 16'h1230 + 16'(2 * (c - 1)) : 16'h4560 + 16'(2 * (c - 14));
      w = memory_data_valid;
      o = !w ? 3'd0 : c <= 12 ? 3'(c - 5) : 3'(c - 18);
      t = c == 12 || c == 25;
      exp = {b, e, a, w, o, t, memory_data};
      tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL back_to_back c=%0d got %h exp %h", c, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_top_address();
    logic        b, e, w, t;
    logic [15:0] a;
    logic [2:0]  o;
    miss_address = 16'hFFFF;
    for (int c = 0; c <= 13; c++) begin
      miss_detected = c == 0;
      memory_data_valid = c >= 5 && c <= 12;
      memory_data = memory_data_valid ? 16'hD000 + 16'(c) : 16'h0000;
      @(negedge clk);
      b = c >= 1 && c <= 12;
      e = c >= 1 && c <= 8;
      a = e ? 16'hFFF0 + 16'(2 * (c - 1)) : 16'h0;
      w = memory_data_valid;
      o = w ? 3'(c - 5) : 3'd0;
      t = c == 12;
      exp = {b, e, a, w, o, t, memory_data};
      tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL top_address c=%0d got %h exp %h", c, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid_fill();
    logic        b, e, w;
    logic [15:0] a;
    miss_address = 16'h2000;
    for (int c = 0; c <= 13; c++) begin
      miss_detected = c == 0;
      rst = c == 6;
      memory_data_valid = c >= 5 && c <= 12;
      memory_data = 16'hE000 + 16'(c);
      @(negedge clk);
      b = c >= 1 && c <= 5;
      e = c >= 1 && c <= 5;
      a = e ? 16'h2000 + 16'(2 * (c - 1)) : 16'h0;
      w = c == 5;
      exp = {b, e, a, w, 3'd0, 1'b0, memory_data};
      if (c != 6) begin
        tests++;
        if (got !== exp) begin
          failed++;
          $display("FAIL reset_mid_fill c=%0d got %h exp %h", c, got, exp);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask
  task automatic test_stray_valid();
    miss_detected = 1'b0;
    memory_data_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      memory_data = 16'h7770 + 16'(c);
      @(negedge clk);
      exp = {1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 16'h7770 + 16'(c)};
      tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL stray_valid c=%0d got %h exp %h", c, got, exp);
      end
      @(posedge clk); #1;
    end
    memory_data_valid = 1'b0;
  endtask
  task automatic test_valid_gaps();
    int          vc[8] = '{5, 7, 8, 11, 12, 13, 16, 20};
    int          k;
    logic        b, e, w, t;
    logic [15:0] a;
    logic [2:0]  o;
    miss_address = 16'h0A5C;
    for (int c = 0; c <= 22; c++) begin
      k = -1;
      for (int j = 0; j < 8; j++) if (vc[j] == c) k = j;
      miss_detected = c == 0;
      memory_data_valid = k >= 0;
      memory_data = k >= 0 ? 16'hC000 + 16'(k) : 16'h3333;
      @(negedge clk);
      b = c >= 1 && c <= 20;
      e = c >= 1 && c <= 8;
      a = e ? 16'h0A50 + 16'(2 * (c - 1)) : 16'h0;
      w = k >= 0;
      o = w ? 3'(k) : 3'd0;
      t = c == 20;
      exp = {b, e, a, w, o, t, memory_data};
      tests++;
      if (got !== exp) begin
        failed++;
        $display("FAIL valid_gaps c=%0d got %h exp %h", c, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_top_address();
    test_reset_mid_fill();
    test_stray_valid();
    test_valid_gaps();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
